// File: rtl/fc_ctrl_pkg.sv
// Shared types and width helpers for the fully-connected layer sequencer.
package fc_ctrl_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Counter/address width with a floor of one bit so N=1 or M=1 still elaborates.
    function automatic int cw(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/fc_lat_pipe.sv
// LAT-stage valid shift register; realigns accumulate enables with the
// synchronous read latency of vector memory and weight ROM.
module fc_lat_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] stages;

    generate
        if (LAT == 1) begin : g_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) stages <= '0;
                else     stages <= din;
            end
        end else begin : g_many
            always_ff @(posedge clk or posedge rst) begin
                if (rst) stages <= '0;
                else     stages <= {stages[LAT-2:0], din};
            end
        end
    endgenerate

    assign dout = stages[LAT-1];

endmodule

// File: rtl/fc_seq_ctrl.sv
// Sequencer for y = W*x: loads N input words, then per row issues N
// memory/ROM reads, waits for the read pipe to drain and presents the result.
module fc_seq_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int M   = 8,
    parameter int N   = 8,
    parameter int LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic                  output_ready,
    output logic                  output_valid,
    output logic [cw(N)-1:0]      addr_x,
    output logic                  wr_en_x,
    output logic [cw(M*N)-1:0]    addr_w,
    output logic                  clear_acc,
    output logic                  en_acc,
    output logic                  layer_done,
    output logic [1:0]            fsm_state
);

    localparam int XW = cw(N);
    localparam int WW = cw(M*N);
    localparam int RW = cw(M);
    localparam int DW = cw(LAT);

    localparam logic [XW-1:0] X_LAST   = XW'(N - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
    localparam logic [DW-1:0] D_LAST   = DW'(LAT - 1);
    localparam logic [WW-1:0] N_STEP   = WW'(N);

    state_t          state;
    logic [XW-1:0]   load_cnt;
    logic [XW-1:0]   col;
    logic [RW-1:0]   row;
    logic [WW-1:0]   row_base;
    logic [DW-1:0]   drain_cnt;
    logic            issue;

    // Both handshakes transfer on a rising edge where valid and ready are high
    // together; ready/valid never depend combinationally on the other side.
    assign wr_en_x    = input_valid & input_ready;
    assign layer_done = output_valid & output_ready & (row == ROW_LAST);
    assign addr_x     = (state == S_LOAD) ? load_cnt : col;
    assign fsm_state  = state;

    fc_lat_pipe #(.LAT(LAT)) u_lat_pipe (
        .clk  (clk),
        .rst  (reset),
        .din  (issue),
        .dout (en_acc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_LOAD;
            load_cnt     <= '0;
            col          <= '0;
            row          <= '0;
            row_base     <= '0;
            addr_w       <= '0;
            drain_cnt    <= '0;
            input_ready  <= 1'b0;
            output_valid <= 1'b0;
            clear_acc    <= 1'b0;
            issue        <= 1'b0;
        end else begin
            clear_acc <= 1'b0;
            issue     <= 1'b0;
            case (state)
                S_LOAD: begin
                    input_ready <= 1'b1;
                    if (wr_en_x) begin
                        if (load_cnt == X_LAST) begin
                            load_cnt    <= '0;
                            input_ready <= 1'b0;
                            row         <= '0;
                            row_base    <= '0;
                            col         <= '0;
                            addr_w      <= '0;
                            clear_acc   <= 1'b1;
                            issue       <= 1'b1;
                            state       <= S_MAC;
                        end else begin
                            load_cnt <= load_cnt + XW'(1);
                        end
                    end
                end
                // addr_w tracks row_base + col incrementally, so no adder on col.
                S_MAC: begin
                    if (col == X_LAST) begin
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end else begin
                        col    <= col + XW'(1);
                        addr_w <= addr_w + WW'(1);
                        issue  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == D_LAST) begin
                        output_valid <= 1'b1;
                        state        <= S_OUT;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                S_OUT: begin
                    if (output_ready) begin
                        output_valid <= 1'b0;
                        col          <= '0;
                        if (row == ROW_LAST) begin
                            row         <= '0;
                            row_base    <= '0;
                            addr_w      <= '0;
                            input_ready <= 1'b1;
                            state       <= S_LOAD;
                        end else begin
                            row       <= row + RW'(1);
                            row_base  <= row_base + N_STEP;
                            addr_w    <= row_base + N_STEP;
                            clear_acc <= 1'b1;
                            issue     <= 1'b1;
                            state     <= S_MAC;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Bench for fc_seq_ctrl: default 8x8 LAT=1 instance wrapped in a behavioural
// memory/ROM/accumulator, plus a 3x5 LAT=2 instance for timing.
module tb_fc_seq_ctrl;
    import fc_ctrl_pkg::*;

    localparam int M = 8;
    localparam int N = 8;

    // clock/reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, input_valid, output_ready;
    logic       input_ready, output_valid, wr_en_x, clear_acc, en_acc, layer_done;
    logic [2:0] addr_x;
    logic [5:0] addr_w;
    logic [1:0] fsm_state;

    logic       rst2, input_valid2, output_ready2;
    logic       input_ready2, output_valid2, wr_en_x2, clear_acc2, en_acc2, layer_done2;
    logic [2:0] addr_x2;
    logic [3:0] addr_w2;
    logic [1:0] fsm_state2;

    fc_seq_ctrl #(.M(8), .N(8), .LAT(1)) dut (
        .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready),
        .output_ready(output_ready), .output_valid(output_valid), .addr_x(addr_x),
        .wr_en_x(wr_en_x), .addr_w(addr_w), .clear_acc(clear_acc), .en_acc(en_acc),
        .layer_done(layer_done), .fsm_state(fsm_state)
    );

    fc_seq_ctrl #(.M(3), .N(5), .LAT(2)) dut2 (
        .clk(clk), .reset(rst2), .input_valid(input_valid2), .input_ready(input_ready2),
        .output_ready(output_ready2), .output_valid(output_valid2), .addr_x(addr_x2),
        .wr_en_x(wr_en_x2), .addr_w(addr_w2), .clear_acc(clear_acc2), .en_acc(en_acc2),
        .layer_done(layer_done2), .fsm_state(fsm_state2)
    );

    // behavioural datapath: vector memory, weight ROM, accumulator
    logic [7:0]  din;
    logic [7:0]  x_mem [8];
    logic [7:0]  xq, wq;
    logic [31:0] acc;
    int          vec [8];

    function automatic logic [7:0] wrom(input int a);
        return 8'((a * 7 + 3) % 11);
    endfunction

    function automatic logic [31:0] golden(input int r);
        logic [31:0] s;
        s = 32'd0;
        for (int c = 0; c < N; c++) s += 32'(wrom(r * N + c)) * 32'(vec[c]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (wr_en_x) x_mem[addr_x] <= din;
        xq <= x_mem[addr_x];
        wq <= wrom(int'(addr_w));
        if (clear_acc)   acc <= 32'd0;
        else if (en_acc) acc <= acc + 32'(xq) * 32'(wq);
    end

    // scoreboard
    logic [31:0] exp_q [$];
    int n_pass = 0;
    int n_total = 0;
    int n_acc = 0;
    int n_done = 0;
    int mon_row = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // monitor: pops an expected row result on every output handshake
    always @(negedge clk) begin
        if (layer_done && !(output_valid && output_ready)) begin
            n_total++;
            $display("FAIL layer_done_spurious: got 1, expected 0");
        end
        if (layer_done) n_done++;
        if (output_valid && output_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL row_result_unexpected: got %0d, expected none", acc);
            end else begin
                check($sformatf("row_result[%0d]", mon_row), acc, exp_q.pop_front());
            end
            check($sformatf("layer_done_at_row[%0d]", mon_row), 32'(layer_done), 32'(mon_row == M - 1));
            mon_row = (mon_row == M - 1) ? 0 : mon_row + 1;
            n_acc++;
        end
    end

    // driver tasks
    task automatic load_vec(input bit bubbles, output int ready_cycles);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        ready_cycles = 0;
        while (k < N && cyc < 100) begin
            input_valid = bubbles ? ((cyc % 3) != 1) : 1'b1;
            din = 8'(vec[k]);
            @(negedge clk);
            if (input_ready) ready_cycles++;
            if (input_ready && input_valid) begin
                check($sformatf("load_addr_x[%0d]", k), 32'(addr_x), 32'(k));
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        input_valid = 1'b0;
        if (k < N) check("load_timeout", 32'(k), 32'(N));
    endtask

    task automatic push_layer();
        for (int r = 0; r < M; r++) exp_q.push_back(golden(r));
    endtask

    task automatic wait_done(input int target, input string name);
        int cyc;
        cyc = 0;
        while (n_done < target && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        check(name, 32'(n_done), 32'(target));
    endtask

    logic [15:0] clr_b, en_b, ov_b;
    int          aw [16];
    int          ax [16];
    logic        ir0;

    initial begin
        int rc;
        int cyc;
        int k;
        int d2;
        int issued [$];
        logic [7:0] en2_b, ov2_b;

        reset = 1'b1; input_valid = 1'b1; output_ready = 1'b1; din = 8'd0;
        rst2 = 1'b1; input_valid2 = 1'b0; output_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({input_ready, output_valid, wr_en_x, addr_x, addr_w,
                                    clear_acc, en_acc, layer_done}), 32'd0);
        check("reset_state", 32'(fsm_state), 32'(S_LOAD));
        @(posedge clk); #1;
        reset = 1'b0;
        output_ready = 1'b0;

        // layer 1: x = 1..8, row 0 held under backpressure for 5 cycles
        vec = '{1, 2, 3, 4, 5, 6, 7, 8};
        load_vec(1'b0, rc);
        check("load_ready_cycles", 32'(rc), 32'd8);
        push_layer();
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (t == 0) ir0 = input_ready;
            clr_b[t] = clear_acc;
            en_b[t]  = en_acc;
            ov_b[t]  = output_valid;
            aw[t]    = int'(addr_w);
            ax[t]    = int'(addr_x);
            @(posedge clk); #1;
            if (t == 13) output_ready = 1'b1;
        end
        check("ready_low_after_load", 32'(ir0), 32'd0);
        check("row0_clear_pattern", 32'(clr_b), 32'h8001);
        check("row0_en_pattern", 32'(en_b), 32'h01FE);
        check("row0_valid_pattern", 32'(ov_b), 32'h7E00);
        for (int t = 0; t < 16; t++) begin
            check($sformatf("row0_addr_w[t%0d]", t), 32'(aw[t]), 32'((t < 8) ? t : ((t < 15) ? 7 : 8)));
            check($sformatf("row0_addr_x[t%0d]", t), 32'(ax[t]), 32'((t < 8) ? t : ((t < 15) ? 7 : 0)));
        end
        wait_done(1, "layer1_done_count");
        @(negedge clk);
        check("ready_after_layer", 32'(input_ready), 32'd1);
        check("layer1_queue_drained", 32'(exp_q.size()), 32'd0);

        // layer 2: reset asserted in the middle of row 3
        @(posedge clk); #1;
        output_ready = 1'b1;
        vec = '{5, 3, 0, 7, 2, 9, 4, 6};
        load_vec(1'b0, rc);
        push_layer();
        k = n_acc + 3;
        cyc = 0;
        while (n_acc < k && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        check("rows_before_reset", 32'(n_acc), 32'(k));
        repeat (4) @(posedge clk);
        #1;
        check("mid_row_state", 32'(fsm_state), 32'(S_MAC));
        input_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_outputs", 32'({input_ready, output_valid, wr_en_x, addr_x, addr_w,
                                        clear_acc, en_acc, layer_done}), 32'd0);
        exp_q.delete();
        mon_row = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // layer 3: fresh load with input_valid bubbles
        vec = '{8, 6, 4, 2, 1, 3, 5, 7};
        load_vec(1'b1, rc);
        push_layer();
        wait_done(2, "layer3_done_count");
        @(negedge clk);
        check("layer3_queue_drained", 32'(exp_q.size()), 32'd0);

        // M=3, N=5, LAT=2 instance
        @(posedge clk); #1;
        rst2 = 1'b0;
        input_valid2 = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 5 && cyc < 50) begin
            @(negedge clk);
            if (input_ready2 && input_valid2) k++;
            @(posedge clk); #1;
            cyc++;
        end
        input_valid2 = 1'b0;
        check("dut2_loaded", 32'(k), 32'd5);
        d2 = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (fsm_state2 == S_MAC) issued.push_back(int'(addr_w2));
            if (t < 8) begin
                en2_b[t] = en_acc2;
                ov2_b[t] = output_valid2;
            end
            if (layer_done2) d2++;
            @(posedge clk); #1;
        end
        check("dut2_en_lag", 32'(en2_b), 32'h7C);
        check("dut2_valid_latency", 32'(ov2_b), 32'h80);
        check("dut2_issue_count", 32'(issued.size()), 32'd15);
        for (int i = 0; i < issued.size(); i++)
            check($sformatf("dut2_addr_w[%0d]", i), 32'(issued[i]), 32'(i));
        check("dut2_layer_done", 32'(d2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/fc_seq_ctrl.md
Name: fc_seq_ctrl

Overview:
- Sequencing controller for the fully-connected matrix-vector engine: accumulator datapath, vector memory and weight ROM, computing y = W*x with M outputs and N inputs.
- Accepts N input words into vector memory over a valid/ready handshake.
- Then walks the M*N weight addresses row by row and drives clear_acc/en_acc.
- Presents each row result through an output valid/ready handshake.
- Compensates for synchronous read latency of memory and ROM with an internal delay line.

Parameters:
- M, 8, number of output rows.
- N, 8, number of input elements per row.
- LAT, 1, read latency in cycles of vector memory and weight ROM (>=1, equal for both).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- input_valid  input  1  upstream has an input word.
- input_ready  output  1  controller accepts an input word this cycle.
- output_ready  input  1  downstream accepts the current result.
- output_valid  output  1  result in datapath output register is valid.
- addr_x  output  max(1,$clog2(N))  vector memory address.
- wr_en_x  output  1  vector memory write enable.
- addr_w  output  max(1,$clog2(M*N))  weight ROM address.
- clear_acc  output  1  one-cycle accumulator clear.
- en_acc  output  1  accumulate product this cycle.
- layer_done  output  1  one-cycle pulse when the last row result is accepted.

Behaviour:
- Reset (async, active-high): state=S_LOAD; all counters, the delay line and layer_done=0; every output held 0 while reset is high.
- States: S_LOAD, S_MAC, S_DRAIN, S_OUT.
- S_LOAD:
  - input_ready=1; wr_en_x = input_valid & input_ready; addr_x = load count.
  - Count increments on each handshake; input_valid bubbles are allowed.
  - After the N-th handshake: go to S_MAC with row=0, col=0.
- S_MAC (one address issue per cycle):
  - addr_x=col; addr_w=row_base+col, with row_base a running sum (+N per row, no multiplier).
  - clear_acc=1 only in the col==0 cycle.
  - Each issue pushes a 1 into an LAT-stage delay line; en_acc = delay-line output, so en_acc is high LAT cycles after each issue.
  - After col==N-1 is issued: go to S_DRAIN.
- S_DRAIN:
  - Lasts exactly LAT cycles; no new issues, so the delay line empties.
  - Then go to S_OUT.
- S_OUT:
  - output_valid=1; addr_x, addr_w, en_acc and clear_acc held stable/low until output_ready.
  - On handshake with row<M-1: row+1, row_base+N, go to S_MAC.
  - On handshake with row==M-1: layer_done=1 for that cycle, go to S_LOAD.
- Latency from S_MAC entry to output_valid: N+LAT cycles (9 at defaults).
- Per-row cost: N+LAT cycles plus 1 handshake cycle minimum.
- Boundaries:
  - input_valid is ignored outside S_LOAD; output_ready is ignored outside S_OUT.
  - output_ready tied high gives back-to-back rows with no stall.
  - clear_acc never coincides with en_acc of the previous row, because S_DRAIN plus S_OUT separate them.
  - N=1 and M=1 must work (counter width floor of 1).
  - Counters do not wrap past N-1 or M-1.
  - Reset mid-operation discards the partial layer; the next layer starts at load count 0.

Decomposition:
- Package fc_ctrl_pkg: state enum typedef (S_LOAD, S_MAC, S_DRAIN, S_OUT) and width helper functions/localparams for address widths.
- One sub-module: fc_lat_pipe, a parameterised LAT-stage valid shift register with async reset that produces en_acc.

Test Plan:
- Reset, then input_valid=1 for 8 words -> input_ready high exactly 8 cycles, wr_en_x with addr_x 0..7, then input_ready=0.
- Row 0 with output_ready=1:
  - clear_acc single pulse with addr_w=0; addr_w 0..7 on consecutive cycles.
  - en_acc high in cycles 1..8; output_valid in cycle 9.
- Backpressure: output_ready low 5 cycles in S_OUT -> output_valid held, no en_acc/clear_acc, addr stable; after accept, next issue starts at addr_w=8.
- Full layer against the complete FC top with x = {1..8} -> 8 results match golden W*x, layer_done pulses once, input_ready returns high.
- Reset asserted mid-row 3 -> all outputs 0 immediately; the following layer produces correct results from load count 0.
- M=3, N=5, LAT=2 -> addr_w runs 0..14, en_acc lags issue by 2 cycles, output_valid 7 cycles after S_MAC entry.
